// File: rtl/dataout_buf_0.sv
// dataout_buf_0 -- transmit-side frame buffer.
// Collects one frame of DEPTH result words, then replays it as DEPTH flits
// {word, seq[3:0]} on a valid/ready stream. It mirrors the datain buffer,
// which strips the low nibble to recover each word.
//
// Ports
//   clk        clock, rising edge
//   RST        synchronous active-high reset
//   wr_valid   result word present on wr_data
//   wr_data    result word (DIN_W)
//   wr_ready   buffer accepts a word (FILL only)
//   out_valid  flit present on dataout (DRAIN only)
//   dataout    {mem[raddr], raddr[3:0]} (DOUT_W)
//   out_ready  downstream accepts the flit
//   full       high while a complete frame is held (DRAIN)
//   done       one-cycle pulse after the last flit is accepted
module dataout_buf_0 #(
  parameter int DEPTH  = 30,
  parameter int AW     = 5,
  parameter int DIN_W  = 16,
  parameter int DOUT_W = 20
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              wr_valid,
  input  logic [DIN_W-1:0]  wr_data,
  output logic              wr_ready,
  output logic              out_valid,
  output logic [DOUT_W-1:0] dataout,
  input  logic              out_ready,
  output logic              full,
  output logic              done
);

  typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [DIN_W-1:0] mem [DEPTH];
  logic [AW-1:0]    waddr, raddr;
  logic             wr_fire, rd_fire, wr_last, rd_last;

  assign wr_fire = wr_valid & wr_ready;
  assign rd_fire = out_valid & out_ready;
  assign wr_last = (waddr == AW'(DEPTH-1));
  assign rd_last = (raddr == AW'(DEPTH-1));

  // Flit = stored word plus the low nibble of the read address; the nibble
  // wraps inside a frame, which the receiver tolerates because it drops it.
  assign dataout = {mem[raddr], raddr[3:0]};

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    out_valid = 1'b0;
    full      = 1'b0;
    done      = 1'b0;
    case (state)
      FILL: begin
        wr_ready = 1'b1;
        if (wr_fire && wr_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        full      = 1'b1;
        if (rd_fire && rd_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state <= FILL;
      waddr <= '0;
      raddr <= '0;
    end else begin
      state <= state_nxt;
      if (wr_fire) waddr <= wr_last ? '0 : waddr + 1'b1;
      if (rd_fire) raddr <= rd_last ? '0 : raddr + 1'b1;
    end
  end

  // Frame storage carries no reset; only valid words are ever read back.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[waddr] <= wr_data;
  end

endmodule

// File: tb/tb_dataout_buf_0.sv
module tb_dataout_buf_0;
  localparam int DEPTH = 30;

  logic        clk = 1'b0;
  logic        RST;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        out_valid;
  logic [19:0] dataout;
  logic        out_ready;
  logic        full;
  logic        done;

  int checks = 0;
  int errors = 0;

  dataout_buf_0 dut (
    .clk(clk), .RST(RST), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .out_valid(out_valid), .dataout(dataout),
    .out_ready(out_ready), .full(full), .done(done)
  );

  always #5 clk = ~clk;

  // advance one clock and settle past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write DEPTH words base+i, with 'gap' idle cycles between pulses.
  // full must stay low until the last write has been accepted.
  task automatic fill_frame(input logic [15:0] base, input int gap, input string name);
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (wr_ready !== 1'b1 || full !== 1'b0) begin
        errors++;
        $display("FAIL %s fill word %0d: wr_ready=%b full=%b, want 1 0", name, i, wr_ready, full);
      end
      wr_valid = 1'b1;
      wr_data  = base + 16'(i);
      step();
      if (i != DEPTH-1) begin
        for (int g = 0; g < gap; g++) begin
          wr_valid = 1'b0;
          wr_data  = 16'hBEEF;
          step();
        end
      end
    end
    wr_valid = 1'b0;
  endtask

  // Accept n flits from a frame written as base+i. out_ready follows pat
  // (bit p%6, LSB first). When all DEPTH flits go, check the DONE pulse.
  task automatic drain(input logic [15:0] base, input int n, input logic [5:0] pat,
                       input string name);
    int k = 0;
    int p = 0;
    int cyc = 0;
    logic [19:0] exp;
    while (k < n && cyc < 400) begin
      exp = {base + 16'(k), 4'(k)};
      checks++;
      if (out_valid !== 1'b1 || full !== 1'b1 || wr_ready !== 1'b0 || dataout !== exp) begin
        errors++;
        $display("FAIL %s flit %0d: valid=%b full=%b wr_ready=%b data=%h, want 1 1 0 %h",
                 name, k, out_valid, full, wr_ready, dataout, exp);
      end
      out_ready = pat[p % 6];
      step();
      if (pat[p % 6]) k++;
      p++;
      cyc++;
    end
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL %s drain timeout: accepted %0d, want %0d", name, k, n);
    end
    out_ready = 1'b0;
    if (n == DEPTH) begin
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || full !== 1'b0 || wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s done cycle: done=%b valid=%b full=%b wr_ready=%b, want 1 0 0 0",
                 name, done, out_valid, full, wr_ready);
      end
      step();
      checks++;
      if (done !== 1'b0 || wr_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s after done: done=%b wr_ready=%b valid=%b, want 0 1 0",
                 name, done, wr_ready, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; wr_valid = 1'b0; wr_data = '0; out_ready = 1'b0;
    step(); step();
    RST = 1'b0;
    checks++;
    if (wr_ready !== 1'b1 || out_valid !== 1'b0 || full !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: wr_ready=%b valid=%b full=%b done=%b, want 1 0 0 0",
               wr_ready, out_valid, full, done);
    end
  endtask

  task automatic test_nominal();
    fill_frame(16'h1000, 0, "T1");
    drain(16'h1000, DEPTH, 6'b111111, "T1");
  endtask

  task automatic test_backpressure();
    fill_frame(16'h2000, 0, "T2");
    drain(16'h2000, DEPTH, 6'b101001, "T2");
  endtask

  task automatic test_gappy_writes();
    fill_frame(16'h3000, 2, "T3");
    drain(16'h3000, DEPTH, 6'b111111, "T3");
  endtask

  task automatic test_writes_in_drain();
    fill_frame(16'h4000, 0, "T4");
    wr_valid = 1'b1;
    wr_data  = 16'hDEAD;
    drain(16'h4000, DEPTH, 6'b110111, "T4");
    wr_valid = 1'b0;
    fill_frame(16'h4100, 0, "T4b");
    drain(16'h4100, DEPTH, 6'b111111, "T4b");
  endtask

  task automatic test_reset_mid_drain();
    fill_frame(16'h5000, 0, "T5");
    drain(16'h5000, 12, 6'b111111, "T5");
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || full !== 1'b0 || wr_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL T5 post-reset: valid=%b full=%b wr_ready=%b done=%b, want 0 0 1 0",
               out_valid, full, wr_ready, done);
    end
    fill_frame(16'h8000, 0, "T5b");
    drain(16'h8000, DEPTH, 6'b111111, "T5b");
  endtask

  task automatic test_back_to_back();
    fill_frame(16'h6000, 0, "T6");
    // keep presenting the next frame's first word through DRAIN and DONE
    wr_valid = 1'b1;
    wr_data  = 16'h7000;
    drain(16'h6000, DEPTH, 6'b111111, "T6");
    fill_frame(16'h7000, 0, "T6b");
    drain(16'h7000, DEPTH, 6'b111111, "T6b");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_gappy_writes();
    test_writes_in_drain();
    test_reset_mid_drain();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
